// File: rtl/fu_alu_pipe.sv
// Pipelined ADD/SUB/SLT/SLTU unit with tag carry-through; result valid LATENCY cycles after accept.
// Global stall when the head is not taken (in_ready = ~stall); flush kills everything in flight.
module fu_alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 3,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  idle
);

  typedef struct packed {
    logic                  vld;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] res;
  } stage_t;

  stage_t                stg [LATENCY];
  logic                  stall;
  logic                  accept;
  logic                  any_vld;
  logic [DATA_WIDTH-1:0] alu_res;

  assign stall     = stg[LATENCY-1].vld & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = stg[LATENCY-1].vld;
  assign result    = stg[LATENCY-1].res;
  assign tag_out   = stg[LATENCY-1].tag;
  assign idle      = ~any_vld & ~in_valid;

  always_comb begin
    alu_res = '0;
    case (op)
      2'b00: alu_res = data_1 + data_0;
      2'b01: alu_res = data_1 - data_0;
      2'b10: alu_res[0] = $signed(data_1) < $signed(data_0);
      default: alu_res[0] = data_1 < data_0;
    endcase
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_vld = any_vld | stg[i].vld;
  end

  // Priority: reset, then flush (overrides stall), then global stall hold, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) stg[i].vld <= 1'b0;
    end else if (!stall) begin
      stg[0].vld <= accept;
      stg[0].tag <= tag_in;
      stg[0].res <= alu_res;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Scoreboard bench: default-parameter instance (A) plus an 8-bit, single-stage instance (B).
module tb_fu_alu_pipe;
  localparam int LA = 3;
  localparam int LB = 1;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    int          acc;
    int          s0;
    bit          seen;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_idle;
  logic [1:0]  a_op;
  logic [31:0] a_d0, a_d1, a_result;
  logic [5:0]  a_tag_in, a_tag_out;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_idle;
  logic [1:0]  b_op;
  logic [7:0]  b_d0, b_d1, b_result;
  logic [5:0]  b_tag_in, b_tag_out;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0, bad = 0, cyc = 0, stall_a = 0, stall_b = 0;
  bit rand_rdy = 0;

  fu_alu_pipe #(.DATA_WIDTH(32), .LATENCY(LA), .TAG_WIDTH(6)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op(a_op), .data_0(a_d0), .data_1(a_d1), .tag_in(a_tag_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .result(a_result), .tag_out(a_tag_out), .idle(a_idle));

  fu_alu_pipe #(.DATA_WIDTH(8), .LATENCY(LB), .TAG_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .data_0(b_d0), .data_1(b_d1), .tag_in(b_tag_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .result(b_result), .tag_out(b_tag_out), .idle(b_idle));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: operands taken mod 2^w, signed view by subtracting 2^w when the top bit is set.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x1,
                                         input logic [31:0] x0, input int w);
    longint m  = longint'(1) << w;
    longint u1 = longint'(x1) % m;
    longint u0 = longint'(x0) % m;
    longint s1 = (u1 >= m / 2) ? u1 - m : u1;
    longint s0 = (u0 >= m / 2) ? u0 - m : u0;
    longint r;
    case (o)
      2'd0:    r = (u1 + u0) % m;
      2'd1:    r = (u1 - u0 + m) % m;
      2'd2:    r = (s1 < s0) ? 1 : 0;
      default: r = (u1 < u0) ? 1 : 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) qa.delete();
    else begin
      check("a_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
      check("a_idle", a_idle, (qa.size() == 0) && !a_in_valid);
      if (a_out_valid) begin
        if (qa.size() == 0) check("a_spurious_out_valid", a_out_valid, 0);
        else begin
          check("a_result", a_result, qa[0].res);
          check("a_tag", a_tag_out, qa[0].tag);
          if (!qa[0].seen) check("a_latency", cyc - qa[0].acc, LA + stall_a - qa[0].s0);
          qa[0].seen = 1;
        end
      end
      if (a_flush) qa.delete();
      else if (a_out_valid && a_out_ready && qa.size() > 0) void'(qa.pop_front());
      if (a_out_valid && !a_out_ready && !a_flush) stall_a++;
    end
  end

  always @(negedge clk) begin
    if (rst) qb.delete();
    else begin
      check("b_in_ready", b_in_ready, !(b_out_valid && !b_out_ready));
      check("b_idle", b_idle, (qb.size() == 0) && !b_in_valid);
      if (b_out_valid) begin
        if (qb.size() == 0) check("b_spurious_out_valid", b_out_valid, 0);
        else begin
          check("b_result", b_result, qb[0].res[7:0]);
          check("b_tag", b_tag_out, qb[0].tag);
          if (!qb[0].seen) check("b_latency", cyc - qb[0].acc, LB + stall_b - qb[0].s0);
          qb[0].seen = 1;
        end
      end
      if (b_flush) qb.delete();
      else if (b_out_valid && b_out_ready && qb.size() > 0) void'(qb.pop_front());
      if (b_out_valid && !b_out_ready && !b_flush) stall_b++;
    end
  end

  always @(posedge clk) if (rand_rdy) begin
    #1 a_out_ready = ($urandom % 4) != 0;
  end

  task automatic issue(input bit is_b, input logic [1:0] o, input logic [31:0] x1,
                       input logic [31:0] x0, input logic [5:0] t);
    exp_t e;
    bit done = 0;
    if (is_b) begin b_in_valid = 1; b_op = o; b_d1 = x1[7:0]; b_d0 = x0[7:0]; b_tag_in = t; end
    else begin a_in_valid = 1; a_op = o; a_d1 = x1; a_d0 = x0; a_tag_in = t; end
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!rst && (is_b ? (b_in_ready && !b_flush) : (a_in_ready && !a_flush))) begin
        e.res = model(o, x1, x0, is_b ? 8 : 32);
        e.tag = t; e.acc = cyc; e.s0 = is_b ? stall_b : stall_a; e.seen = 0;
        if (is_b) qb.push_back(e); else qa.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (is_b) b_in_valid = 0; else a_in_valid = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout: op not accepted, got none expected accept");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_op = 0; a_d0 = 0; a_d1 = 0; a_tag_in = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_op = 0; b_d0 = 0; b_d1 = 0; b_tag_in = 0;
    cycles(3);
    rst = 0;
    @(negedge clk);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_result", a_result, 0);
    check("rst_a_tag_out", a_tag_out, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_idle", a_idle, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_result", b_result, 0);
    check("rst_b_idle", b_idle, 1);
    @(posedge clk); #1;

    // Single ADD, then idle returns
    issue(0, 2'd0, 32'd5, 32'd3, 6'h12);
    cycles(5);
    @(negedge clk);
    check("idle_after_add", a_idle, 1);
    @(posedge clk); #1;

    // Back-to-back
    issue(0, 2'd1, 32'd10, 32'd3, 6'd1);
    issue(0, 2'd1, 32'd0, 32'd1, 6'd2);
    issue(0, 2'd2, 32'hFFFFFFFF, 32'd1, 6'd3);
    issue(0, 2'd3, 32'hFFFFFFFF, 32'd1, 6'd4);
    cycles(6);

    // Backpressure: 3 in flight, 5 stalled cycles
    a_out_ready = 0;
    issue(0, 2'd0, 32'd100, 32'd1, 6'd7);
    issue(0, 2'd1, 32'd100, 32'd1, 6'd8);
    issue(0, 2'd2, 32'd1, 32'd100, 6'd9);
    cycles(5);
    @(negedge clk);
    check("bp_head_held", a_out_valid, 1);
    check("bp_in_ready_low", a_in_ready, 0);
    @(posedge clk); #1;
    a_out_ready = 1;
    cycles(6);

    // Flush with 2 in flight plus a same-cycle issue
    issue(0, 2'd0, 32'd1, 32'd1, 6'd20);
    issue(0, 2'd0, 32'd2, 32'd2, 6'd21);
    a_flush = 1; a_in_valid = 1; a_op = 2'd0; a_tag_in = 6'd22;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0;
    for (int k = 0; k < LA + 2; k++) begin
      @(negedge clk);
      check("flush_out_valid_low", a_out_valid, 0);
      if (k == 0) check("flush_idle", a_idle, 1);
      @(posedge clk); #1;
    end

    // Flush while stalled
    a_out_ready = 0;
    issue(0, 2'd0, 32'd9, 32'd9, 6'd30);
    for (int k = 0; k < 20 && !a_out_valid; k++) cycles(1);
    check("stalled_head_present", a_out_valid, 1);
    a_flush = 1;
    @(posedge clk); #1;
    a_flush = 0;
    @(negedge clk);
    check("flush_stall_out_valid", a_out_valid, 0);
    check("flush_stall_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_out_ready = 1;

    // Overflow, then 8-bit single-stage instance
    issue(0, 2'd0, 32'h7FFFFFFF, 32'd1, 6'd31);
    issue(1, 2'd0, 32'hFF, 32'h01, 6'h12);
    cycles(5);
    for (int k = 0; k < 30; k++) issue(1, 2'($urandom), rnd_val(), rnd_val(), 6'($urandom));

    // Reset mid-stream
    issue(0, 2'd0, 32'd1, 32'd2, 6'd40);
    issue(0, 2'd0, 32'd3, 32'd4, 6'd41);
    b_in_valid = 1; a_in_valid = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; a_in_valid = 0; b_in_valid = 0;
    for (int k = 0; k < LA + 3; k++) begin
      @(negedge clk);
      check("post_rst_a_out_valid", a_out_valid, 0);
      check("post_rst_b_out_valid", b_out_valid, 0);
      @(posedge clk); #1;
    end

    // Randomised traffic with random backpressure and occasional flushes
    rand_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 30 == 0) begin
        a_flush = 1; a_in_valid = 1'($urandom);
        @(posedge clk); #1;
        a_flush = 0; a_in_valid = 0;
      end else if ($urandom % 5 == 0) cycles(1);
      else issue(0, 2'($urandom), rnd_val(), rnd_val(), 6'($urandom));
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    a_out_ready = 1;
    for (int k = 0; k < 200 && (qa.size() != 0 || qb.size() != 0); k++) cycles(1);
    cycles(2);
    check("drain_a_empty", qa.size(), 0);
    check("drain_b_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
- Parametrised, fully pipelined integer add/subtract/compare functional unit for the superscalar RISC-V back end.
- Successor to the single-operation, non-pipelined subtract FU.
- Adds per-issue opcode select, tag carry-through for writeback matching, valid/ready handshake on both sides, one-result-per-cycle throughput, and branch-mispredict flush.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (>=2).
- LATENCY, 3, cycles from accept to result valid; integer >=1.
- TAG_WIDTH, 6, width of the ROB/rename tag carried with each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  issue-side operation present.
- in_ready  output  1  FU can accept this cycle.
- op  input  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU.
- data_0  input  DATA_WIDTH  operand 0.
- data_1  input  DATA_WIDTH  operand 1.
- tag_in  input  TAG_WIDTH  tag of the issued operation.
- out_valid  output  1  result present at stage LATENCY.
- out_ready  input  1  writeback/CDB accepts the result.
- result  output  DATA_WIDTH  result of the head operation.
- tag_out  output  TAG_WIDTH  tag of the head operation.
- idle  output  1  no operation in flight and no new issue.

Behaviour:
- Reset: rst clears every stage valid bit; stage data and tag registers are cleared to 0. After reset, out_valid=0, result=0, tag_out=0, in_ready=1, idle=1 (with in_valid=0).
- Arithmetic, computed combinationally at entry from the operands, captured into stage 1:
  - ADD = data_1 + data_0, mod 2^DATA_WIDTH.
  - SUB = data_1 - data_0, mod 2^DATA_WIDTH.
  - SLT = {0..0, $signed(data_1) < $signed(data_0)}.
  - SLTU = {0..0, data_1 < data_0}, unsigned.
- Pipeline: stages 1..LATENCY, each holding valid, result and tag. Stage LATENCY drives out_valid, result and tag_out.
- Stall: stall = out_valid & ~out_ready.
  - While stalled, all stages hold (global stall; no bubble collapsing).
  - in_ready = ~stall.
- Accept: an operation is accepted when in_valid & in_ready & ~flush.
  - An accepted op appears on the output exactly LATENCY rising edges later if no stall occurs in between.
  - Each stall cycle delays it by one cycle.
- Throughput: one accept per cycle while unstalled; back-to-back ops emerge on consecutive cycles in issue order.
- Handshake:
  - A result is consumed on the edge where out_valid & out_ready.
  - result and tag_out stay stable while out_valid=1 and out_ready=0.
  - When not accepted, stage 1 loads valid=0 (bubble).
- Flush:
  - On an edge with flush=1, every stage valid bit is cleared. out_valid=0 on the following cycle.
  - An input presented in the same cycle is dropped, even if in_valid=1.
  - Flush overrides stall. The result at the head during a flush cycle is treated as not consumed, even if out_ready=1.
- Priority: rst > flush > stall > normal advance.
- idle = ~(OR of all stage valid bits) & ~in_valid. Combinational, matching the existing FU convention that a pending issue deasserts idle.
- LATENCY=1: single stage, still registered output. Accept at edge N gives out_valid at edge N.
- Reset mid-operation: all in-flight ops are discarded; no spurious out_valid after reset.

Test Plan:
- Reset, then ADD with data_1=5, data_0=3, tag 0x12, out_ready=1 -> out_valid for exactly 1 cycle, 3 cycles after accept, result=8, tag_out=0x12; idle returns to 1.
- Four back-to-back ops:
  - SUB 10-3 -> 7.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT data_1=0xFFFFFFFF, data_0=1 -> 1.
  - SLTU, same operands -> 0.
  - Tags 1..4 -> results on 4 consecutive cycles, in order, with matching tags.
- Backpressure: 3 ops in flight, out_ready=0 for 5 cycles -> head result and tag held stable, in_ready=0 throughout, no op lost or duplicated; all 3 drain in order once out_ready=1.
- Flush with 2 ops in flight plus in_valid=1 in the flush cycle -> out_valid stays 0 for the next LATENCY+2 cycles; idle=1 once in_valid drops.
- Flush while stalled (out_valid=1, out_ready=0) -> out_valid=0 next cycle and in_ready=1.
- Overflow and parameterisation:
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - Rerun the first scenario with LATENCY=1 and DATA_WIDTH=8: 0xFF+0x01 -> 0x00, one cycle after accept.
  - rst asserted mid-stream -> no output afterwards.
